ram_arbiter: RTL

- Shares the single-ported data/instruction RAM between two requesters: instruction fetch (IFU, read-only) and load/store (LSU, read/write with byte enables).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Every access gets a registered response one cycle after grant.
- Sits between the pipeline front-end/MEM stage and the RAM, and drives the RAM address, enable, byte-enable and write-data pins directly.

---
 rtl/ram_arbiter_pkg.sv | 26 ++
 rtl/ram_arbiter_if.sv | 56 +++++
 rtl/ram_arbiter_resp_slot.sv | 50 +++++
 rtl/ram_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared constants and types for the RAM arbiter.
// XLEN is the data/address width. DEF_RAM_LEN and DEF_STARVE_MAX are the default values for the
// top-level parameters. RAM_SIZE is the RAM size in bytes. GNT_* is the grant encoding.
package ram_arbiter_pkg;

  localparam int unsigned XLEN           = 64;
  localparam int unsigned DEF_RAM_LEN    = 12;
  localparam int unsigned DEF_STARVE_MAX = 4;
  localparam int unsigned RAM_SIZE       = 1 << DEF_RAM_LEN;

  typedef logic [1:0] gnt_t;

  localparam gnt_t GNT_NONE = 2'd0;
  localparam gnt_t GNT_IF   = 2'd1;
  localparam gnt_t GNT_LS   = 2'd2;

  // A doubleword access at addr fits when addr + 7 < 2**ram_len.
  // This is the same as addr <= 2**ram_len - 8, which avoids the overflow of addr + 7.
  function automatic logic addr_in_range(input logic [XLEN-1:0] addr,
                                         input int unsigned     ram_len);
    logic [XLEN-1:0] last_ok;
    last_ok = (XLEN'(1) << ram_len) - XLEN'(8);
    return addr <= last_ok;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundles the signals between the arbiter and its environment: the IFU request/response
// channels, the LSU request/response channels, and the RAM pins.
// slave  : arbiter side (takes requests, drives responses and RAM pins)
// master : environment side (requesters plus RAM read data)
interface ram_arbiter_if;

  localparam int unsigned XLEN = ram_arbiter_pkg::XLEN;

  // IFU channels
  logic            if_req_valid;
  logic            if_req_ready;
  logic [XLEN-1:0] if_req_addr;
  logic            if_resp_valid;
  logic            if_resp_ready;
  logic [XLEN-1:0] if_resp_rdata;
  logic            if_resp_err;

  // LSU channels
  logic            ls_req_valid;
  logic            ls_req_ready;
  logic [XLEN-1:0] ls_req_addr;
  logic            ls_req_wen;
  logic [7:0]      ls_req_byte_en;
  logic [XLEN-1:0] ls_req_wdata;
  logic            ls_resp_valid;
  logic            ls_resp_ready;
  logic [XLEN-1:0] ls_resp_rdata;
  logic            ls_resp_err;

  // RAM pins
  logic [XLEN-1:0] ram_addr_o;
  logic            ram_ren_o;
  logic            ram_wen_o;
  logic [7:0]      ram_byte_en_o;
  logic [XLEN-1:0] ram_wdata_o;
  logic [XLEN-1:0] ram_rdata_i;

  modport slave (
    input  if_req_valid, if_req_addr, if_resp_ready,
    output if_req_ready, if_resp_valid, if_resp_rdata, if_resp_err,
    input  ls_req_valid, ls_req_addr, ls_req_wen, ls_req_byte_en, ls_req_wdata, ls_resp_ready,
    output ls_req_ready, ls_resp_valid, ls_resp_rdata, ls_resp_err,
    output ram_addr_o, ram_ren_o, ram_wen_o, ram_byte_en_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output if_req_valid, if_req_addr, if_resp_ready,
    input  if_req_ready, if_resp_valid, if_resp_rdata, if_resp_err,
    output ls_req_valid, ls_req_addr, ls_req_wen, ls_req_byte_en, ls_req_wdata, ls_resp_ready,
    input  ls_req_ready, ls_resp_valid, ls_resp_rdata, ls_resp_err,
    input  ram_addr_o, ram_ren_o, ram_wen_o, ram_byte_en_o, ram_wdata_o,
    output ram_rdata_i
  );

endinterface

// File: rtl/ram_arbiter_resp_slot.sv
// Single-entry response register with a valid/ready output.
// clk, rst_n : clock and asynchronous active-low reset
// i_load     : capture i_rdata/i_err and assert o_valid (the requester was granted this cycle)
// i_rdata    : data to capture
// i_err      : error flag to capture
// i_ready    : the consumer takes the held response
// o_valid    : response present
// o_rdata    : held data
// o_err      : held error flag
module ram_arbiter_resp_slot #(
  parameter int unsigned Width = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [Width-1:0] i_rdata,
  input  logic             i_err,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [Width-1:0] o_rdata,
  output logic             o_err
);

  logic             r_valid;
  logic [Width-1:0] r_rdata;
  logic             r_err;

  // A load takes priority over a drain. This lets a response be handed over and replaced
  // in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_rdata <= i_rdata;
      r_err   <= i_err;
    end else if (i_ready) begin
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_rdata = r_rdata;
  assign o_err   = r_err;

endmodule

// File: rtl/ram_arbiter.sv
// Shares a single-ported RAM between the instruction fetch unit (IFU, reads only) and the
// load/store unit (LSU, reads and byte-enabled writes).
// It makes one combinational grant per cycle and drives the RAM pins directly. The response
// is registered and appears one cycle after the grant.
// clk, rst_n : clock and asynchronous active-low reset
// bus        : IFU/LSU request and response channels plus the RAM pins (slave modport)
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned RAM_LEN    = DEF_RAM_LEN,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input logic          clk,
  input logic          rst_n,
  ram_arbiter_if.slave bus
);

  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic            w_if_elig;
  logic            w_ls_elig;
  logic            w_if_in_range;
  logic            w_ls_in_range;
  gnt_t            w_gnt;
  logic [XLEN-1:0] w_if_rdata;
  logic [XLEN-1:0] w_ls_rdata;
  logic [CntW-1:0] r_starve_cnt;

  assign w_if_in_range = addr_in_range(bus.if_req_addr, RAM_LEN);
  assign w_ls_in_range = addr_in_range(bus.ls_req_addr, RAM_LEN);

  // The response slot is free if it is empty, or if it is being drained this cycle.
  assign w_if_elig = bus.if_req_valid && (!bus.if_resp_valid || bus.if_resp_ready);
  assign w_ls_elig = bus.ls_req_valid && (!bus.ls_resp_valid || bus.ls_resp_ready);

  // The grant is held off during reset, so no RAM enable can fire at an edge under reset.
  always_comb begin
    w_gnt = GNT_NONE;
    if (rst_n) begin
      if (w_ls_elig && (!w_if_elig || r_starve_cnt != CntW'(STARVE_MAX))) begin
        w_gnt = GNT_LS;
      end else if (w_if_elig) begin
        w_gnt = GNT_IF;
      end
    end
  end

  assign bus.if_req_ready = (w_gnt == GNT_IF);
  assign bus.ls_req_ready = (w_gnt == GNT_LS);

  // Count LSU wins while the IFU is eligible but loses.
  // The count clears on an IFU grant or when the IFU stops asking.
  // It holds while the IFU is blocked only by its own full response slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_gnt == GNT_IF || !bus.if_req_valid) begin
      r_starve_cnt <= '0;
    end else if (w_gnt == GNT_LS && w_if_elig && r_starve_cnt != CntW'(STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + CntW'(1);
    end
  end

  // RAM drive. An out-of-range access is still granted but asserts no enable.
  always_comb begin
    bus.ram_addr_o    = '0;
    bus.ram_ren_o     = 1'b0;
    bus.ram_wen_o     = 1'b0;
    bus.ram_byte_en_o = '0;
    bus.ram_wdata_o   = '0;
    case (w_gnt)
      GNT_IF: begin
        bus.ram_addr_o = bus.if_req_addr;
        bus.ram_ren_o  = w_if_in_range;
      end
      GNT_LS: begin
        bus.ram_addr_o  = bus.ls_req_addr;
        bus.ram_wdata_o = bus.ls_req_wdata;
        bus.ram_ren_o   = w_ls_in_range && !bus.ls_req_wen;
        bus.ram_wen_o   = w_ls_in_range && bus.ls_req_wen;
        if (w_ls_in_range && bus.ls_req_wen) begin
          bus.ram_byte_en_o = bus.ls_req_byte_en;
        end
      end
      default: ;
    endcase
  end

  // Only in-range reads return RAM data. Writes and errors return zero.
  assign w_if_rdata = w_if_in_range ? bus.ram_rdata_i : '0;
  assign w_ls_rdata = (w_ls_in_range && !bus.ls_req_wen) ? bus.ram_rdata_i : '0;

  ram_arbiter_resp_slot #(
    .Width (XLEN)
  ) u_if_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_gnt == GNT_IF),
    .i_rdata (w_if_rdata),
    .i_err   (!w_if_in_range),
    .i_ready (bus.if_resp_ready),
    .o_valid (bus.if_resp_valid),
    .o_rdata (bus.if_resp_rdata),
    .o_err   (bus.if_resp_err)
  );

  ram_arbiter_resp_slot #(
    .Width (XLEN)
  ) u_ls_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_gnt == GNT_LS),
    .i_rdata (w_ls_rdata),
    .i_err   (!w_ls_in_range),
    .i_ready (bus.ls_resp_ready),
    .o_valid (bus.ls_resp_valid),
    .o_rdata (bus.ls_resp_rdata),
    .o_err   (bus.ls_resp_err)
  );

endmodule
